muldiv_issue_arbiter: RTL and testbench

- Shares the single iterative multiply/divide unit (MDU) between issue slot 0 and issue slot 1 of the dual-issue execute stage.
- Slot 0 is older, so it always wins when both slots request in the same cycle. The slot 1 request is parked in a pending buffer and issued to the MDU right after the slot 0 operation completes.
- Stalls the EX pipeline until every accepted MD operation has returned its result.
- Tags each result with the slot it belongs to, for writeback routing.

---
 rtl/muldiv_issue_arbiter.sv | 152 +++++++++++++++
 tb/tb_muldiv_issue_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_issue_arbiter.sv
// Shares one iterative multiply/divide unit between the two issue slots of the dual-issue EX stage.
// Slot 0 (older) is served first; a simultaneous slot 1 request is parked and issued after slot 0 completes.
module muldiv_issue_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ALU_OP_WIDTH = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req0_valid,
    input  logic [ALU_OP_WIDTH-1:0] req0_op,
    input  logic [DATA_WIDTH-1:0]   req0_s1,
    input  logic [DATA_WIDTH-1:0]   req0_s2,
    input  logic                    req1_valid,
    input  logic [ALU_OP_WIDTH-1:0] req1_op,
    input  logic [DATA_WIDTH-1:0]   req1_s1,
    input  logic [DATA_WIDTH-1:0]   req1_s2,
    input  logic                    flush,
    output logic                    mdu_start,
    output logic [ALU_OP_WIDTH-1:0] mdu_op,
    output logic [DATA_WIDTH-1:0]   mdu_s1,
    output logic [DATA_WIDTH-1:0]   mdu_s2,
    output logic                    mdu_kill,
    input  logic                    mdu_done,
    input  logic [DATA_WIDTH-1:0]   mdu_result,
    output logic                    res_valid,
    output logic                    res_slot,
    output logic [DATA_WIDTH-1:0]   res_data,
    output logic                    md_stall
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    pend_q, pend_d;
    logic                    cur_slot_q, cur_slot_d;
    logic [ALU_OP_WIDTH-1:0] iss_op_q, iss_op_d;
    logic [DATA_WIDTH-1:0]   iss_s1_q, iss_s1_d;
    logic [DATA_WIDTH-1:0]   iss_s2_q, iss_s2_d;
    logic [ALU_OP_WIDTH-1:0] pnd_op_q, pnd_op_d;
    logic [DATA_WIDTH-1:0]   pnd_s1_q, pnd_s1_d;
    logic [DATA_WIDTH-1:0]   pnd_s2_q, pnd_s2_d;

    logic busy;
    logic any_req;

    assign busy    = (state_q != IDLE);
    assign any_req = req0_valid | req1_valid;

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        cur_slot_d = cur_slot_q;
        iss_op_d   = iss_op_q;
        iss_s1_d   = iss_s1_q;
        iss_s2_d   = iss_s2_q;
        pnd_op_d   = pnd_op_q;
        pnd_s1_d   = pnd_s1_q;
        pnd_s2_d   = pnd_s2_q;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d    = ISSUE;
                    cur_slot_d = ~req0_valid;
                    if (req0_valid) begin
                        iss_op_d = req0_op;
                        iss_s1_d = req0_s1;
                        iss_s2_d = req0_s2;
                    end else begin
                        iss_op_d = req1_op;
                        iss_s1_d = req1_s1;
                        iss_s2_d = req1_s2;
                    end
                    if (req0_valid && req1_valid) begin
                        pend_d   = 1'b1;
                        pnd_op_d = req1_op;
                        pnd_s1_d = req1_s1;
                        pnd_s2_d = req1_s2;
                    end
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (mdu_done) begin
                    if (pend_q) begin
                        // Parked slot 1 goes out right behind the slot 0 result.
                        state_d    = ISSUE;
                        pend_d     = 1'b0;
                        cur_slot_d = 1'b1;
                        iss_op_d   = pnd_op_q;
                        iss_s1_d   = pnd_s1_q;
                        iss_s2_d   = pnd_s2_q;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d    = IDLE;
            pend_d     = 1'b0;
            cur_slot_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pend_q     <= 1'b0;
            cur_slot_q <= 1'b0;
            iss_op_q   <= '0;
            iss_s1_q   <= '0;
            iss_s2_q   <= '0;
            pnd_op_q   <= '0;
            pnd_s1_q   <= '0;
            pnd_s2_q   <= '0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            cur_slot_q <= cur_slot_d;
            iss_op_q   <= iss_op_d;
            iss_s1_q   <= iss_s1_d;
            iss_s2_q   <= iss_s2_d;
            pnd_op_q   <= pnd_op_d;
            pnd_s1_q   <= pnd_s1_d;
            pnd_s2_q   <= pnd_s2_d;
        end
    end

    assign mdu_start = (state_q == ISSUE);
    assign mdu_op    = busy ? iss_op_q : '0;
    assign mdu_s1    = busy ? iss_s1_q : '0;
    assign mdu_s2    = busy ? iss_s2_q : '0;
    // rst resets the MDU directly, so only a true flush needs the kill pulse.
    assign mdu_kill  = flush & busy & ~rst;

    assign res_valid = (state_q == WAIT) & mdu_done & ~flush & ~rst;
    assign res_slot  = res_valid & cur_slot_q;
    assign res_data  = res_valid ? mdu_result : '0;

    assign md_stall  = ~flush & ~rst &
                       (((state_q == IDLE) & any_req) |
                        (state_q == ISSUE) |
                        ((state_q == WAIT) & ~(mdu_done & ~pend_q)));

endmodule

// File: tb/tb_muldiv_issue_arbiter.sv
// Per-cycle vector bench: directed sequences plus random transactions expanded from a transaction-level model.
module tb_muldiv_issue_arbiter;

    localparam logic [4:0] MUL = 5'h0C;
    localparam logic [4:0] DIV = 5'h0E;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic        req0_valid, req1_valid;
    logic [4:0]  req0_op, req1_op;
    logic [31:0] req0_s1, req0_s2, req1_s1, req1_s2;
    logic        mdu_start, mdu_kill, mdu_done;
    logic [4:0]  mdu_op;
    logic [31:0] mdu_s1, mdu_s2, mdu_result;
    logic        res_valid, res_slot, md_stall;
    logic [31:0] res_data;

    always #5 clk = ~clk;

    muldiv_issue_arbiter #(.DATA_WIDTH(32), .ALU_OP_WIDTH(5)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_s1(req0_s1), .req0_s2(req0_s2),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_s1(req1_s1), .req1_s2(req1_s2),
        .flush(flush),
        .mdu_start(mdu_start), .mdu_op(mdu_op), .mdu_s1(mdu_s1), .mdu_s2(mdu_s2),
        .mdu_kill(mdu_kill), .mdu_done(mdu_done), .mdu_result(mdu_result),
        .res_valid(res_valid), .res_slot(res_slot), .res_data(res_data),
        .md_stall(md_stall)
    );

    typedef struct {
        logic        rst, flush;
        logic        r0v, r1v;
        logic [4:0]  r0op, r1op;
        logic [31:0] r0s1, r0s2, r1s1, r1s2;
        logic        done;
        logic [31:0] dres;
        logic        e_start;
        logic [4:0]  e_op;
        logic [31:0] e_s1, e_s2;
        logic        e_kill, e_rv, e_slot;
        logic [31:0] e_data;
        logic        e_stall;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    // Request currently held by upstream; copied into every row pushed.
    logic        h_r0v, h_r1v;
    logic [4:0]  h_r0op, h_r1op;
    logic [31:0] h_r0s1, h_r0s2, h_r1s1, h_r1s2;

    task automatic set_req(input logic v0, input logic [4:0] o0, input logic [31:0] a0, input logic [31:0] b0,
                           input logic v1, input logic [4:0] o1, input logic [31:0] a1, input logic [31:0] b1);
        h_r0v = v0; h_r0op = o0; h_r0s1 = a0; h_r0s2 = b0;
        h_r1v = v1; h_r1op = o1; h_r1s1 = a1; h_r1s2 = b1;
    endtask

    task automatic row(input logic r, input logic f, input logic d, input logic [31:0] dr,
                       input logic es, input logic [4:0] eo, input logic [31:0] e1, input logic [31:0] e2,
                       input logic ek, input logic ev, input logic esl, input logic [31:0] ed,
                       input logic est);
        vec_t v;
        v.rst = r; v.flush = f; v.done = d; v.dres = dr;
        v.r0v = h_r0v; v.r0op = h_r0op; v.r0s1 = h_r0s1; v.r0s2 = h_r0s2;
        v.r1v = h_r1v; v.r1op = h_r1op; v.r1s1 = h_r1s1; v.r1s2 = h_r1s2;
        v.e_start = es; v.e_op = eo; v.e_s1 = e1; v.e_s2 = e2;
        v.e_kill = ek; v.e_rv = ev; v.e_slot = esl; v.e_data = ed; v.e_stall = est;
        vecs.push_back(v);
    endtask

    task automatic idle_row(input logic d, input logic [31:0] dr);
        row(1'b0, 1'b0, d, dr, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    endtask

    function automatic logic [31:0] md_res(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op == MUL) return a * b;
        return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
    endfunction

    // Transaction model: the older valid slot issues first, each issue is one start cycle
    // followed by lat cycles ending in done; stall holds until the last result of the group.
    task automatic gen_txn();
        logic [1:0]  sel;
        logic        sl [2];
        logic [4:0]  op [2];
        logic [31:0] a [2], b [2], rs [2];
        int          lat [2];
        int          n, total, fc, c;
        logic        stop;
        logic [4:0]  o0, o1;
        logic [31:0] a0, b0, a1, b1;

        sel = 2'($urandom_range(1, 3));
        o0 = ($urandom_range(0, 1) == 0) ? MUL : DIV;
        o1 = ($urandom_range(0, 1) == 0) ? MUL : DIV;
        a0 = $urandom; b0 = $urandom_range(0, 1000);
        a1 = $urandom; b1 = $urandom_range(0, 1000);
        set_req(sel[0], o0, a0, b0, sel[1], o1, a1, b1);

        n = 0;
        if (sel[0]) begin sl[n] = 1'b0; op[n] = o0; a[n] = a0; b[n] = b0; n++; end
        if (sel[1]) begin sl[n] = 1'b1; op[n] = o1; a[n] = a1; b[n] = b1; n++; end
        total = 1;
        for (int k = 0; k < n; k++) begin
            lat[k] = $urandom_range(1, 4);
            rs[k]  = md_res(op[k], a[k], b[k]);
            total += 1 + lat[k];
        end
        fc = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, total - 1)) : -1;

        stop = 1'b0;
        if (fc == 0) begin
            row(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
            stop = 1'b1;
        end else begin
            row(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        end
        c = 1;
        for (int k = 0; k < n && !stop; k++) begin
            if (c == fc) begin
                row(1'b0, 1'b1, 1'($urandom_range(0, 1)), $urandom, 1'b1, op[k], a[k], b[k],
                    1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
                stop = 1'b1;
            end else begin
                row(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, op[k], a[k], b[k], 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
            end
            c++;
            for (int j = 1; j <= lat[k] && !stop; j++) begin
                if (c == fc) begin
                    row(1'b0, 1'b1, 1'(j == lat[k]), rs[k], 1'b0, op[k], a[k], b[k],
                        1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
                    stop = 1'b1;
                end else if (j == lat[k]) begin
                    row(1'b0, 1'b0, 1'b1, rs[k], 1'b0, op[k], a[k], b[k],
                        1'b0, 1'b1, sl[k], rs[k], 1'(k != n - 1));
                end else begin
                    row(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, op[k], a[k], b[k], 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
                end
                c++;
            end
        end

        set_req(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0);
        if (stop) idle_row(1'($urandom_range(0, 1)), $urandom);
        repeat ($urandom_range(0, 2)) idle_row(1'($urandom_range(0, 1)), $urandom);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0h want %0h", name, idx, act, exp);
        end
    endtask

    initial begin
        set_req(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0);

        // reset state
        row(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);

        // single slot 0 MUL 7*6, done three cycles after start
        set_req(1'b1, MUL, 32'd7, 32'd6, 1'b0, 5'd0, 32'd0, 32'd0);
        row(1'b0, 1'b0, 1'b0, 32'd0,  1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0,  1'b1);
        row(1'b0, 1'b0, 1'b0, 32'd0,  1'b1, MUL,  32'd7, 32'd6, 1'b0, 1'b0, 1'b0, 32'd0,  1'b1);
        row(1'b0, 1'b0, 1'b0, 32'd0,  1'b0, MUL,  32'd7, 32'd6, 1'b0, 1'b0, 1'b0, 32'd0,  1'b1);
        row(1'b0, 1'b0, 1'b0, 32'd0,  1'b0, MUL,  32'd7, 32'd6, 1'b0, 1'b0, 1'b0, 32'd0,  1'b1);
        row(1'b0, 1'b0, 1'b1, 32'd42, 1'b0, MUL,  32'd7, 32'd6, 1'b0, 1'b1, 1'b0, 32'd42, 1'b0);
        set_req(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0);
        idle_row(1'b0, 32'd0);

        // single slot 1 DIV 100/7
        set_req(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, DIV, 32'd100, 32'd7);
        row(1'b0, 1'b0, 1'b0, 32'd0,  1'b0, 5'd0, 32'd0,   32'd0, 1'b0, 1'b0, 1'b0, 32'd0,  1'b1);
        row(1'b0, 1'b0, 1'b0, 32'd0,  1'b1, DIV,  32'd100, 32'd7, 1'b0, 1'b0, 1'b0, 32'd0,  1'b1);
        row(1'b0, 1'b0, 1'b1, 32'd14, 1'b0, DIV,  32'd100, 32'd7, 1'b0, 1'b1, 1'b1, 32'd14, 1'b0);
        set_req(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0);
        idle_row(1'b0, 32'd0);

        // dual: MUL 3*5 then DIV 20/4
        set_req(1'b1, MUL, 32'd3, 32'd5, 1'b1, DIV, 32'd20, 32'd4);
        row(1'b0, 1'b0, 1'b0, 32'd0,  1'b0, 5'd0, 32'd0,  32'd0, 1'b0, 1'b0, 1'b0, 32'd0,  1'b1);
        row(1'b0, 1'b0, 1'b0, 32'd0,  1'b1, MUL,  32'd3,  32'd5, 1'b0, 1'b0, 1'b0, 32'd0,  1'b1);
        row(1'b0, 1'b0, 1'b1, 32'd15, 1'b0, MUL,  32'd3,  32'd5, 1'b0, 1'b1, 1'b0, 32'd15, 1'b1);
        row(1'b0, 1'b0, 1'b0, 32'd0,  1'b1, DIV,  32'd20, 32'd4, 1'b0, 1'b0, 1'b0, 32'd0,  1'b1);
        row(1'b0, 1'b0, 1'b1, 32'd5,  1'b0, DIV,  32'd20, 32'd4, 1'b0, 1'b1, 1'b1, 32'd5,  1'b0);
        set_req(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0);
        idle_row(1'b0, 32'd0);

        // flush during WAIT of a dual pair: no result, no slot 1 issue afterward
        set_req(1'b1, MUL, 32'd3, 32'd5, 1'b1, DIV, 32'd20, 32'd4);
        row(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        row(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, MUL,  32'd3, 32'd5, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        row(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, MUL,  32'd3, 32'd5, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        set_req(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0);
        idle_row(1'b0, 32'd0);
        idle_row(1'b1, 32'd15);
        idle_row(1'b0, 32'd0);

        // stray done in ISSUE ignored, then flush coincident with done
        set_req(1'b1, MUL, 32'd2, 32'd9, 1'b0, 5'd0, 32'd0, 32'd0);
        row(1'b0, 1'b0, 1'b0, 32'd0,  1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        row(1'b0, 1'b0, 1'b1, 32'd77, 1'b1, MUL,  32'd2, 32'd9, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        row(1'b0, 1'b0, 1'b0, 32'd0,  1'b0, MUL,  32'd2, 32'd9, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        row(1'b0, 1'b1, 1'b1, 32'd18, 1'b0, MUL,  32'd2, 32'd9, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        set_req(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0);
        idle_row(1'b0, 32'd0);

        // stray done in IDLE, then rst mid-WAIT and a clean restart
        idle_row(1'b1, 32'd99);
        set_req(1'b1, MUL, 32'd4, 32'd4, 1'b0, 5'd0, 32'd0, 32'd0);
        row(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        row(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, MUL,  32'd4, 32'd4, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        row(1'b1, 1'b0, 1'b1, 32'd16, 1'b0, MUL, 32'd4, 32'd4, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        set_req(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0);
        idle_row(1'b0, 32'd0);
        set_req(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, DIV, 32'd9, 32'd3);
        row(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        row(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, DIV,  32'd9, 32'd3, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        row(1'b0, 1'b0, 1'b1, 32'd3, 1'b0, DIV,  32'd9, 32'd3, 1'b0, 1'b1, 1'b1, 32'd3, 1'b0);
        set_req(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0);
        idle_row(1'b0, 32'd0);

        repeat (150) gen_txn();

        rst = 1'b1; flush = 1'b0; mdu_done = 1'b0; mdu_result = 32'd0;
        req0_valid = 1'b0; req0_op = 5'd0; req0_s1 = 32'd0; req0_s2 = 32'd0;
        req1_valid = 1'b0; req1_op = 5'd0; req1_s1 = 32'd0; req1_s2 = 32'd0;
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; flush = vecs[i].flush;
            req0_valid = vecs[i].r0v; req0_op = vecs[i].r0op; req0_s1 = vecs[i].r0s1; req0_s2 = vecs[i].r0s2;
            req1_valid = vecs[i].r1v; req1_op = vecs[i].r1op; req1_s1 = vecs[i].r1s1; req1_s2 = vecs[i].r1s2;
            mdu_done = vecs[i].done; mdu_result = vecs[i].dres;
            #1;
            chk("mdu_start", i, 32'(mdu_start), 32'(vecs[i].e_start));
            chk("mdu_op",    i, 32'(mdu_op),    32'(vecs[i].e_op));
            chk("mdu_s1",    i, mdu_s1,         vecs[i].e_s1);
            chk("mdu_s2",    i, mdu_s2,         vecs[i].e_s2);
            chk("mdu_kill",  i, 32'(mdu_kill),  32'(vecs[i].e_kill));
            chk("res_valid", i, 32'(res_valid), 32'(vecs[i].e_rv));
            chk("res_slot",  i, 32'(res_slot),  32'(vecs[i].e_slot));
            chk("res_data",  i, res_data,       vecs[i].e_data);
            chk("md_stall",  i, 32'(md_stall),  32'(vecs[i].e_stall));
            @(posedge clk); #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
